// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register, 1-cycle ROM-to-IF/ID latency.
// stall holds PC and IF/ID; exc, redirect and taken irq override stall; flush inserts a bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC         = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC         = 32'h8000_0008,
  parameter logic [31:0] FETCH_COUNT_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic [31:0] pc_next;
  logic        exc_take;
  logic        irq_take;
  logic        bubble;
  logic        load;

  assign rom_addr = pc;

  // Bit 31 is the kernel-mode flag; the increment wraps inside the low 31 bits only.
  assign pc_seq = {pc[31], pc[30:0] + 31'd4};

  // An exception against an empty IF/ID slot has no instruction to blame, so it is dropped.
  assign exc_take = exc & if_id_valid;
  assign irq_take = irq & ~pc[31] & ~stall & ~exc_take & ~redirect_valid;
  assign bubble   = exc_take | redirect_valid | irq_take | flush;
  assign load     = ~bubble & ~stall;

  // A flush without a new target holds PC so the squashed fetch is reissued.
  always_comb begin
    pc_next = pc_seq;
    if (exc_take)            pc_next = EXC_VEC;
    else if (redirect_valid) pc_next = redirect_pc;
    else if (irq_take)       pc_next = IRQ_VEC;
    else if (stall || flush) pc_next = pc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      if_id_inst  <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
      epc         <= 32'h0;
      epc_we      <= 1'b0;
      fetch_count <= FETCH_COUNT_RST;
    end else begin
      pc     <= pc_next;
      epc_we <= exc_take | irq_take;
      if (bubble) begin
        if_id_inst  <= 32'h0;
        if_id_valid <= 1'b0;
      end else if (load) begin
        if_id_inst  <= rom_data;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
      // Exceptions resume after the faulting instruction; interrupts resume at the unfetched one.
      if (exc_take)      epc <= if_id_pc + 32'd4;
      else if (irq_take) epc <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-level reference model plus literal checkpoints.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] CNT2_INIT = 32'hFFFF_FFFE;

  logic        clk;
  logic        reset;
  logic        stall, flush, redirect_valid, irq, exc;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr, rom_data, if_id_inst, if_id_pc, epc, fetch_count;
  logic        if_id_valid, epc_we;
  logic [31:0] rom_addr2, rom_data2, if_id_inst2, if_id_pc2, epc2, fetch_count2;
  logic        if_id_valid2, epc_we2;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_pc, m_inst, m_ipc, m_epc, m_cnt;
  logic        m_valid, m_we;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0800_0003;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign rom_data  = rom(rom_addr);
  assign rom_data2 = rom(rom_addr2);

  fetch_unit dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irq(irq), .exc(exc), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .epc(epc), .epc_we(epc_we), .fetch_count(fetch_count)
  );

  fetch_unit #(.FETCH_COUNT_RST(CNT2_INIT)) dut_wrap (
    .clk(clk), .reset(reset), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irq(irq), .exc(exc), .if_id_inst(if_id_inst2), .if_id_pc(if_id_pc2),
    .if_id_valid(if_id_valid2), .epc(epc2), .epc_we(epc_we2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("rom_addr",     rom_addr,            m_pc);
    chk("if_id_inst",   if_id_inst,          m_inst);
    chk("if_id_pc",     if_id_pc,            m_ipc);
    chk("if_id_valid",  {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("epc",          epc,                 m_epc);
    chk("epc_we",       {31'b0, epc_we},     {31'b0, m_we});
    chk("fetch_count",  fetch_count,         m_cnt);
    chk("wrap_rom_addr", rom_addr2,          m_pc);
    chk("wrap_count",   fetch_count2,        m_cnt + CNT2_INIT);
  endtask

  // One clock: derive the expected next state from the rules, advance, compare at negedge.
  task automatic tick();
    logic [31:0] n_pc, n_inst, n_ipc, n_epc, n_cnt;
    logic        n_valid, n_we, e, t_irq;
    n_pc = m_pc; n_inst = m_inst; n_ipc = m_ipc; n_epc = m_epc;
    n_cnt = m_cnt; n_valid = m_valid; n_we = 1'b0;
    if (!reset) begin
      n_pc = RESET_PC; n_inst = 0; n_ipc = 0; n_valid = 0; n_epc = 0; n_cnt = 0;
    end else begin
      e     = exc && m_valid;
      t_irq = irq && !m_pc[31] && !stall && !e && !redirect_valid;
      if (e)                   n_pc = EXC_VEC;
      else if (redirect_valid) n_pc = redirect_pc;
      else if (t_irq)          n_pc = IRQ_VEC;
      else if (stall || flush) n_pc = m_pc;
      else if (m_pc[31])       n_pc = (m_pc + 32'd4) | 32'h8000_0000;
      else                     n_pc = (m_pc + 32'd4) & 32'h7FFF_FFFF;
      if (e || redirect_valid || t_irq || flush) begin
        n_inst = 0; n_valid = 0;
      end else if (!stall) begin
        n_inst = rom(m_pc); n_ipc = m_pc; n_valid = 1; n_cnt = m_cnt + 1;
      end
      if (e)          begin n_epc = m_ipc + 32'd4; n_we = 1; end
      else if (t_irq) begin n_epc = m_pc;          n_we = 1; end
    end
    @(posedge clk);
    m_pc = n_pc; m_inst = n_inst; m_ipc = n_ipc; m_valid = n_valid;
    m_epc = n_epc; m_we = n_we; m_cnt = n_cnt;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0; irq = 0; exc = 0;
  endtask

  task automatic jump(input logic [31:0] target);
    redirect_valid = 1; redirect_pc = target;
    tick();
    idle();
  endtask

  logic [31:0] cnt_snap;

  initial begin
    m_pc = 0; m_inst = 0; m_ipc = 0; m_valid = 0; m_epc = 0; m_we = 0; m_cnt = 0;
    idle();
    // Reset with noisy inputs: all must be ignored.
    reset = 0; irq = 1; stall = 1; exc = 1;
    tick(); tick();
    chk("rst_rom_addr", rom_addr, 32'h8000_0000);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_epc_we", {31'b0, epc_we}, 32'h0);
    idle(); reset = 1;

    // First fetch after release.
    tick();
    chk("first_inst", if_id_inst, 32'h0800_0003);
    chk("first_pc", if_id_pc, 32'h8000_0000);
    chk("first_rom_addr", rom_addr, 32'h8000_0004);
    chk("first_count", fetch_count, 32'h1);
    chk("wrap_first_count", fetch_count2, 32'hFFFF_FFFF);

    // User-mode interrupt.
    jump(32'h0000_0100);
    irq = 1; tick(); irq = 0;
    chk("irq_rom_addr", rom_addr, 32'h8000_0004);
    chk("irq_valid", {31'b0, if_id_valid}, 32'h0);
    chk("irq_epc", epc, 32'h0000_0100);
    chk("irq_epc_we", {31'b0, epc_we}, 32'h1);
    tick();
    chk("irq_epc_we_drop", {31'b0, epc_we}, 32'h0);
    chk("wrap_count_zero", fetch_count2, 32'h0);

    // Kernel-mode interrupt is ignored.
    jump(32'h8000_0100);
    irq = 1; tick(); irq = 0;
    chk("kirq_rom_addr", rom_addr, 32'h8000_0104);
    chk("kirq_epc_we", {31'b0, epc_we}, 32'h0);

    // Exception beats simultaneous redirect.
    jump(32'h0000_0040);
    tick();
    exc = 1; redirect_valid = 1; redirect_pc = 32'h0000_0200; tick(); idle();
    chk("exc_rom_addr", rom_addr, 32'h8000_0008);
    chk("exc_epc", epc, 32'h0000_0044);
    chk("exc_valid", {31'b0, if_id_valid}, 32'h0);
    // Exception against a bubble is ignored.
    exc = 1; tick(); idle();
    chk("exc_ign_rom_addr", rom_addr, 32'h8000_000C);
    chk("exc_ign_epc_we", {31'b0, epc_we}, 32'h0);

    // Stall freezes everything; redirect overrides the stall.
    jump(32'h0000_000C);
    tick();
    cnt_snap = fetch_count;
    stall = 1; tick(); tick(); tick();
    chk("stall_rom_addr", rom_addr, 32'h0000_0010);
    chk("stall_if_id_pc", if_id_pc, 32'h0000_000C);
    chk("stall_count", fetch_count, cnt_snap);
    redirect_valid = 1; redirect_pc = 32'h0000_0080; tick(); idle();
    chk("stall_redir", rom_addr, 32'h0000_0080);
    tick();
    // Flush with stall, then flush alone: bubble, PC held.
    stall = 1; flush = 1; tick(); idle();
    chk("flush_stall_valid", {31'b0, if_id_valid}, 32'h0);
    chk("flush_stall_pc", rom_addr, 32'h0000_0084);
    flush = 1; tick(); idle();
    chk("flush_pc", rom_addr, 32'h0000_0084);
    tick();

    // PC wrap within bits 30:0, user and kernel.
    jump(32'h7FFF_FFFC);
    tick();
    chk("wrap_user", rom_addr, 32'h0000_0000);
    jump(32'hFFFF_FFFC);
    tick();
    chk("wrap_kernel", rom_addr, 32'h8000_0000);
    tick(); tick();

    // Reset mid-stall with pending irq and redirect.
    jump(32'h0000_0300);
    tick();
    stall = 1; irq = 1; redirect_valid = 1; redirect_pc = 32'h0000_0500; reset = 0;
    tick();
    chk("mrst_rom_addr", rom_addr, 32'h8000_0000);
    chk("mrst_epc", epc, 32'h0);
    chk("mrst_count", fetch_count, 32'h0);
    idle(); reset = 1;
    tick();
    chk("mrst_first_inst", if_id_inst, 32'h0800_0003);
    chk("mrst_first_pc", if_id_pc, 32'h8000_0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, fetch address after reset (kernel mode).
REQ-002 Parameter IRQ_VEC, default 32'h8000_0004, interrupt handler address.
REQ-003 Parameter EXC_VEC, default 32'h8000_0008, exception handler address.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 rom_addr  output  32  fetch address to instruction ROM; equals PC register, combinational.
REQ-007 rom_data  input  32  instruction word from ROM, combinationally valid for rom_addr.
REQ-008 stall  input  1  hold PC and IF/ID contents.
REQ-009 flush  input  1  replace IF/ID contents with a bubble.
REQ-010 redirect_valid  input  1  branch/jump taken in a later stage.
REQ-011 redirect_pc  input  32  target for redirect_valid.
REQ-012 irq  input  1  level interrupt request.
REQ-013 exc  input  1  exception raised for instruction held in IF/ID.
REQ-014 if_id_inst  output  32  registered instruction.
REQ-015 if_id_pc  output  32  registered address of if_id_inst.
REQ-016 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 epc  output  32  return address captured on interrupt/exception.
REQ-018 epc_we  output  1  one-cycle pulse when epc is updated (writes $k0).
REQ-019 fetch_count  output  32  count of valid instructions loaded into IF/ID.

Function
REQ-020 PC[31] SHALL be the kernel-mode bit; sequential increment SHALL be {PC[31], PC[30:0]+4}, wrapping within bits 30:0 without altering bit 31.
REQ-021 Next-PC priority, highest first: exc -> EXC_VEC; redirect_valid -> redirect_pc; irq taken -> IRQ_VEC; stall -> hold; else sequential.
REQ-022 exc and redirect_valid SHALL take effect regardless of stall.
REQ-023 irq SHALL be taken only when irq=1, PC[31]=0, stall=0, exc=0, redirect_valid=0; otherwise it is deferred (level, no latching).
REQ-024 Normal cycle (no stall/flush/exc/redirect/irq taken): IF/ID <= {rom_data, PC, valid=1}; instruction at address A appears on if_id_inst exactly one cycle after rom_addr=A.
REQ-025 stall alone: PC, IF/ID, fetch_count unchanged.
REQ-026 flush, exc, redirect_valid or irq taken: IF/ID <= bubble (inst=0, pc unchanged, valid=0); flush alone does not change PC.
REQ-027 flush with stall: flush wins for IF/ID; PC held.
REQ-028 irq taken: epc <= current PC (unfetched instruction), epc_we=1 next cycle.
REQ-029 exc: epc <= if_id_pc + 4, epc_we=1 next cycle; exc with if_id_valid=0 SHALL be ignored entirely.
REQ-030 epc_we SHALL be high for exactly one cycle per capture; epc holds otherwise.
REQ-031 fetch_count SHALL increment by 1 only when IF/ID is loaded with valid=1; wraps 32'hFFFF_FFFF -> 0.

Reset
REQ-032 While reset=0 at a rising edge: PC=RESET_PC, if_id_inst=0, if_id_pc=0, if_id_valid=0, epc=0, epc_we=0, fetch_count=0; all inputs ignored.
REQ-033 Reset asserted mid-operation (during stall, pending irq, or redirect) SHALL discard all in-flight state; first fetch after release is RESET_PC.

Verification
REQ-034 Release reset, ROM returns 32'h0800_0003 at 0x8000_0000 -> cycle 1: rom_addr=0x8000_0000; cycle 2: if_id_inst=32'h0800_0003, if_id_pc=0x8000_0000, valid=1, rom_addr=0x8000_0004, fetch_count=1.
REQ-035 PC=0x0000_0100, irq=1, stall=0 -> next: rom_addr=0x8000_0004, if_id_valid=0, epc=0x0000_0100, epc_we=1 for one cycle; with PC=0x8000_0100 irq is ignored.
REQ-036 if_id_pc=0x0000_0040 valid, exc=1 and redirect_valid=1 (0x0000_0200) same cycle -> rom_addr=0x8000_0008, epc=0x0000_0044, bubble in IF/ID.
REQ-037 stall=1 for 3 cycles at PC=0x0000_0010 -> rom_addr, if_id_*, fetch_count frozen; redirect_valid=1 to 0x0000_0080 during stall -> rom_addr=0x0000_0080 next cycle.
REQ-038 PC=0x7FFF_FFFC sequential -> next rom_addr=0x0000_0000; fetch_count preloaded near 32'hFFFF_FFFF wraps to 0; reset=0 mid-stall -> all outputs at REQ-032 values.
